// File: rtl/lsu_pkg.sv
// Shared definitions for the RAM load/store master: funct3 codes, FSM states
// and the store-lane helpers used when a store is accepted.
package lsu_pkg;

    localparam int BE_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_DATA,
        FAULT
    } state_t;

    // funct3[1:0] alone encodes the access width for both loads and stores
    function automatic logic [BE_W-1:0] store_be(input logic [2:0] funct3,
                                                 input logic [1:0] offset);
        logic [BE_W-1:0] be;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << offset;
            2'b01:   be = offset[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0]  funct3,
                                                input logic [31:0] wdata);
        logic [31:0] lanes;
        case (funct3[1:0])
            2'b00:   lanes = {4{wdata[7:0]}};
            2'b01:   lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half/word from the RAM read word and sign- or
// zero-extends it according to the load funct3.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] ram_q,
    input  logic [1:0]        offset,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] lane;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        lane   = ram_q >> {offset, 3'b000};
        byte_s = signed'(lane[7:0]);
        half_s = signed'(lane[15:0]);
        result = '0;
        case (funct3)
            F3_B:    result = DATA_W'(byte_s);
            F3_H:    result = DATA_W'(half_s);
            F3_W:    result = lane;
            F3_BU:   result = DATA_W'(lane[7:0]);
            F3_HU:   result = DATA_W'(lane[15:0]);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/ram_lsu_master.sv
// Load/store initiator for a byte-enabled, registered-read simple dual-port RAM:
// classifies core requests, drives write lanes and extracts load results.
module ram_lsu_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_we,
    output logic [BE_W-1:0]   ram_be,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_q
);

    state_t            state_q, state_d;
    logic [1:0]        off_p0;
    logic [2:0]        f3_p0;
    logic              vld_p1;
    logic              accept;
    logic              illegal, misaligned, out_of_range, fault;
    logic [DATA_W-1:0] ld_result;

    always_comb begin
        if (req_we)
            illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        else
            illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = |(req_addr >> (ADDR_W + 2));
        fault = illegal || misaligned || out_of_range;
    end

    // A FAULT cycle is itself the done cycle, so a new request may be taken there
    assign accept = req && ((state_q == IDLE) || (state_q == FAULT));

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = vld_p1;
        err     = 1'b0;
        case (state_q)
            IDLE, FAULT: begin
                if (state_q == FAULT) begin
                    done = 1'b1;
                    err  = 1'b1;
                end
                if (req)
                    state_d = fault ? FAULT : (req_we ? WRITE : RD_ISSUE);
                else
                    state_d = IDLE;
            end
            WRITE: begin
                busy    = 1'b1;
                state_d = IDLE;
            end
            RD_ISSUE: begin
                busy    = 1'b1;
                state_d = RD_DATA;
            end
            RD_DATA: begin
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    lsu_load_align #(.DATA_W(DATA_W)) u_load_align (
        .ram_q  (ram_q),
        .offset (off_p0),
        .funct3 (f3_p0),
        .result (ld_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vld_p1    <= 1'b0;
            off_p0    <= '0;
            f3_p0     <= '0;
            ram_we    <= 1'b0;
            ram_be    <= '0;
            ram_wdata <= '0;
            ram_waddr <= '0;
            ram_raddr <= '0;
            rdata     <= '0;
        end else begin
            state_q <= state_d;
            // Stage p0: capture the accepted request and present it to the RAM
            if (accept) begin
                off_p0 <= req_addr[1:0];
                f3_p0  <= req_funct3;
            end
            ram_we <= accept && req_we && !fault;
            ram_be <= (accept && req_we && !fault) ? store_be(req_funct3, req_addr[1:0]) : '0;
            if (accept && req_we && !fault) begin
                ram_wdata <= store_lanes(req_funct3, req_wdata);
                ram_waddr <= req_addr[ADDR_W+1:2];
            end
            if (accept && !req_we && !fault)
                ram_raddr <= req_addr[ADDR_W+1:2];
            // Stage p1: completion pulse after the RAM write or the load capture
            vld_p1 <= (state_q == WRITE) || (state_q == RD_DATA);
            if (state_q == RD_DATA)
                rdata <= ld_result;
        end
    end

endmodule
